// File: rtl/riscv_mem_responder.sv
// Memory and I/O responder for a single-cycle RISC-V core.
// The fetch port and the data port work independently in the same cycle.
// Both return registered data one cycle after the request.
// The data port decodes data RAM plus three MMIO registers: LEDs, switches and a cycle counter.
// Bad accesses set a sticky addr_error flag.
module riscv_mem_responder #(
  parameter logic [31:0] INITIAL_PC = 32'h00400000,
  parameter logic [31:0] DATA_BASE  = 32'h10010000,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000,
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        iMemRead,
  output logic [31:0] instruction,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] dReadData,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic        addr_error
);

  localparam logic [31:0] NOP        = 32'h00000013;
  localparam int          IAW        = $clog2(IMEM_WORDS);
  localparam int          DAW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) << 2;
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS) << 2;

  // Memories are never reset, so their contents survive rst.
  logic [31:0] imem_q [IMEM_WORDS];
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] imem_rd_q;
  logic [31:0] dmem_rd_q;

  logic        fetch_ok_q;
  logic        rd_dmem_q;
  logic [31:0] rd_mmio_q;
  logic [15:0] leds_q;
  logic        err_q;
  logic [31:0] cycle_q;
  logic [15:0] sw_meta_q;
  logic [15:0] sw_sync_q;

  logic [31:0] i_off;
  logic [31:0] d_off;
  logic        i_ok;
  logic        d_aligned;
  logic        hit_dmem;
  logic        hit_led;
  logic        hit_sw;
  logic        hit_cnt;
  logic        d_ok;
  logic        d_fault;
  logic        i_fault;
  logic        dmem_we;
  logic        led_we;
  logic        cnt_clr;
  logic        rd_dmem_d;
  logic [31:0] rd_mmio_d;
  logic [31:0] cycle_d;
  logic        err_d;
  logic [IAW-1:0] i_idx;
  logic [DAW-1:0] d_idx;

  // Address decode for both ports and next-state values for the small registers.
  always_comb begin
    i_off     = PC - INITIAL_PC;
    d_off     = dAddress - DATA_BASE;
    i_ok      = (i_off < IMEM_BYTES) && (PC[1:0] == 2'b00);
    i_idx     = i_off[IAW+1:2];
    d_idx     = d_off[DAW+1:2];
    d_aligned = (dAddress[1:0] == 2'b00);
    hit_dmem  = (d_off < DMEM_BYTES);
    hit_led   = (dAddress == MMIO_BASE);
    hit_sw    = (dAddress == MMIO_BASE + 32'd4);
    hit_cnt   = (dAddress == MMIO_BASE + 32'd8);
    d_ok      = d_aligned && (hit_dmem || hit_led || hit_sw || hit_cnt);
    // A simultaneous read and write is still executed.
    // It is flagged because a memory cannot legally do both on one port.
    d_fault   = (MemRead || MemWrite) && (!d_ok || (MemRead && MemWrite));
    i_fault   = iMemRead && !i_ok;
    dmem_we   = MemWrite && d_ok && hit_dmem;
    led_we    = MemWrite && d_ok && hit_led;
    cnt_clr   = MemWrite && d_ok && hit_cnt;
    rd_dmem_d = d_ok && hit_dmem;
    rd_mmio_d = 32'h0;
    if (d_aligned) begin
      if (hit_led)      rd_mmio_d = {16'h0, leds_q};
      else if (hit_sw)  rd_mmio_d = {16'h0, sw_sync_q};
      else if (hit_cnt) rd_mmio_d = cycle_q;
    end
    cycle_d = cnt_clr ? 32'h0 : cycle_q + 32'd1;
    err_d   = err_q || i_fault || d_fault;
  end

  // Control, MMIO and read-select registers; all are cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_ok_q <= 1'b0;
      rd_dmem_q  <= 1'b0;
      rd_mmio_q  <= 32'h0;
      leds_q     <= 16'h0;
      err_q      <= 1'b0;
      cycle_q    <= 32'h0;
      sw_meta_q  <= 16'h0;
      sw_sync_q  <= 16'h0;
    end else begin
      if (iMemRead) fetch_ok_q <= i_ok;
      if (MemRead) begin
        rd_dmem_q <= rd_dmem_d;
        rd_mmio_q <= rd_mmio_d;
      end
      if (led_we) leds_q <= dWriteData[15:0];
      err_q     <= err_d;
      cycle_q   <= cycle_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM write and registered RAM reads; nothing is written on an edge where rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      if (dmem_we) dmem_q[d_idx] <= dWriteData;
      if (MemRead && rd_dmem_d) dmem_rd_q <= dmem_q[d_idx];
      if (iMemRead && i_ok) imem_rd_q <= imem_q[i_idx];
    end
  end

  assign instruction = fetch_ok_q ? imem_rd_q : NOP;
  assign dReadData   = rd_dmem_q ? dmem_rd_q : rd_mmio_q;
  assign leds        = leds_q;
  assign addr_error  = err_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Randomized bench for riscv_mem_responder with a behavioural memory-map model.
module tb_riscv_mem_responder;

  localparam logic [31:0] IPC = 32'h00400000;
  localparam logic [31:0] DB  = 32'h10010000;
  localparam logic [31:0] MB  = 32'hFFFF0000;
  localparam int          IW  = 1024;
  localparam int          DW  = 1024;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = '0, dAddress = '0, dWriteData = '0;
  logic        iMemRead = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
  logic [15:0] switches = '0;
  logic [31:0] instruction, dReadData;
  logic [15:0] leds;
  logic        addr_error;

  riscv_mem_responder dut (
    .clk(clk), .rst(rst), .PC(PC), .iMemRead(iMemRead), .instruction(instruction),
    .dAddress(dAddress), .dWriteData(dWriteData), .MemRead(MemRead), .MemWrite(MemWrite),
    .dReadData(dReadData), .switches(switches), .leds(leds), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model state
  logic [31:0] m_imem [IW];
  logic [31:0] m_dmem [DW];
  bit          m_known [DW];
  logic [31:0] m_instr, m_rdata;
  bit          m_rd_known;
  logic [15:0] m_leds;
  bit          m_err;
  logic [31:0] m_edges, m_cnt_base;
  logic [15:0] m_sw_hist [$];

  task automatic model_reset();
    m_instr = NOP; m_rdata = 32'h0; m_rd_known = 1'b1; m_leds = 16'h0; m_err = 1'b0;
    m_edges = 32'h0; m_cnt_base = 32'h0; m_sw_hist.delete();
  endtask

  // One clock cycle: drive inputs, predict outputs, then check them on the falling edge.
  task automatic step(input logic [31:0] pc, input bit imr, input logic [31:0] addr,
                      input logic [31:0] wd, input bit mr, input bit mw, input logic [15:0] sw);
    logic [31:0] k, cnt_pre, idx;
    logic [15:0] sync_pre;
    logic [63:0] pc64, a64;
    bit aligned, is_dm, is_led, is_sw, is_cnt, mapped;
    PC = pc; iMemRead = imr; dAddress = addr; dWriteData = wd;
    MemRead = mr; MemWrite = mw; switches = sw;
    k        = m_edges + 1;
    cnt_pre  = (k - 1) - m_cnt_base;
    sync_pre = (m_sw_hist.size() >= 2) ? m_sw_hist[m_sw_hist.size()-2] : 16'h0;
    pc64 = {32'h0, pc};
    a64  = {32'h0, addr};
    if (imr) begin
      if (pc64 >= {32'h0, IPC} && pc64 < {32'h0, IPC} + 64'(4*IW) && pc % 4 == 0)
        m_instr = m_imem[(pc - IPC) / 4];
      else begin
        m_instr = NOP; m_err = 1'b1;
      end
    end
    aligned = (addr % 4 == 0);
    is_dm   = (a64 >= {32'h0, DB}) && (a64 < {32'h0, DB} + 64'(4*DW));
    is_led  = (addr == MB);
    is_sw   = (addr == MB + 4);
    is_cnt  = (addr == MB + 8);
    mapped  = is_dm || is_led || is_sw || is_cnt;
    idx     = (addr - DB) / 4;
    if (mr) begin
      m_rd_known = 1'b1;
      if (!aligned || !mapped) m_rdata = 32'h0;
      else if (is_dm) begin
        m_rdata = m_dmem[idx]; m_rd_known = m_known[idx];
      end
      else if (is_led) m_rdata = {16'h0, m_leds};
      else if (is_sw)  m_rdata = {16'h0, sync_pre};
      else             m_rdata = cnt_pre;
    end
    if (mw && aligned) begin
      if (is_dm) begin
        m_dmem[idx] = wd; m_known[idx] = 1'b1;
      end
      else if (is_led) m_leds = wd[15:0];
      else if (is_cnt) m_cnt_base = k;
    end
    if ((mr || mw) && (!aligned || !mapped || (mr && mw))) m_err = 1'b1;
    m_sw_hist.push_back(sw);
    m_edges = k;
    @(posedge clk);
    @(negedge clk);
    $display("txn pc=%h imr=%0d addr=%h wd=%h mr=%0d mw=%0d sw=%h -> instr=%h rd=%h leds=%h err=%0d",
             pc, imr, addr, wd, mr, mw, sw, instruction, dReadData, leds, addr_error);
    check_eq("instruction", instruction, m_instr);
    if (m_rd_known) check_eq("dReadData", dReadData, m_rdata);
    check_eq("leds", {16'h0, leds}, {16'h0, m_leds});
    check_eq("addr_error", {31'h0, addr_error}, {31'h0, m_err});
  endtask

  task automatic idle(input logic [15:0] sw);
    step(IPC, 1'b0, DB, 32'h0, 1'b0, 1'b0, sw);
  endtask

  // Mid-cycle asynchronous reset with a store pending that must not land.
  task automatic do_reset();
    iMemRead = 1'b0; MemRead = 1'b0; MemWrite = 1'b1;
    dAddress = DB + 32'h10; dWriteData = 32'h0BADF00D;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_leds", {16'h0, leds}, 32'h0);
    check_eq("rst_instr", instruction, NOP);
    check_eq("rst_rdata", dReadData, 32'h0);
    check_eq("rst_err", {31'h0, addr_error}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_daddr();
    int r = $urandom_range(0, 9);
    if (r <= 4) return DB + 4 * $urandom_range(0, 15);
    if (r == 5) return DB + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
    if (r == 6) return MB;
    if (r == 7) return MB + 4;
    if (r == 8) return MB + 8;
    case ($urandom_range(0, 2))
      0:       return MB + 12;
      1:       return 32'h20000000;
      default: return IPC;
    endcase
  endfunction

  function automatic logic [31:0] rand_pc();
    int r = $urandom_range(0, 9);
    if (r <= 6) return IPC + 4 * $urandom_range(0, IW - 1);
    if (r == 7) return IPC + 4 * $urandom_range(0, IW - 1) + $urandom_range(1, 3);
    if (r == 8) return 32'h0;
    return IPC + 4 * IW;
  endfunction

  initial begin
    logic [15:0] sw;
    for (int i = 0; i < IW; i++) begin
      m_imem[i] = $urandom;
      if (i == 1) m_imem[i] = 32'h00A00093;
      dut.imem_q[i] = m_imem[i];
    end
    for (int i = 0; i < DW; i++) m_known[i] = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_instr", instruction, NOP);
    check_eq("reset_rdata", dReadData, 32'h0);
    check_eq("reset_leds", {16'h0, leds}, 32'h0);
    check_eq("reset_err", {31'h0, addr_error}, 32'h0);
    rst = 1'b0;
    model_reset();

    // Directed scenarios
    step(IPC + 4, 1'b1, DB, 32'h0, 1'b0, 1'b0, 16'h0);
    check_eq("fetch_word1", instruction, 32'h00A00093);
    step(IPC + 8, 1'b0, DB, 32'h0, 1'b0, 1'b0, 16'h0);
    check_eq("fetch_hold", instruction, 32'h00A00093);
    step(IPC, 1'b0, DB + 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 16'h0);
    step(IPC, 1'b0, DB + 32'h10, 32'h0, 1'b1, 1'b0, 16'h0);
    check_eq("store_load", dReadData, 32'hDEADBEEF);
    step(IPC, 1'b0, MB, 32'h0000A5A5, 1'b0, 1'b1, 16'h0);
    check_eq("led_write", {16'h0, leds}, 32'h0000A5A5);
    idle(16'h1234);
    idle(16'h1234);
    step(IPC, 1'b0, MB + 4, 32'h0, 1'b1, 1'b0, 16'h1234);
    check_eq("switch_read", dReadData, 32'h00001234);
    step(IPC, 1'b0, MB + 8, 32'h0, 1'b0, 1'b1, 16'h1234);
    for (int i = 0; i < 4; i++) idle(16'h1234);
    step(IPC, 1'b0, MB + 8, 32'h0, 1'b1, 1'b0, 16'h1234);
    check_eq("counter_after_clear", dReadData, 32'd4);
    force dut.cycle_q = 32'hFFFFFFFF;
    #1 release dut.cycle_q;
    m_cnt_base = m_edges + 1;
    step(IPC, 1'b0, MB + 8, 32'h0, 1'b1, 1'b0, 16'h1234);
    check_eq("counter_max", dReadData, 32'hFFFFFFFF);
    step(IPC, 1'b0, MB + 8, 32'h0, 1'b1, 1'b0, 16'h1234);
    check_eq("counter_wrap", dReadData, 32'h0);
    step(IPC, 1'b0, DB + 2, 32'h0, 1'b1, 1'b0, 16'h1234);
    check_eq("misaligned_rdata", dReadData, 32'h0);
    check_eq("misaligned_err", {31'h0, addr_error}, 32'h1);
    step(32'h0, 1'b1, DB, 32'h0, 1'b0, 1'b0, 16'h1234);
    check_eq("bad_pc_nop", instruction, NOP);
    idle(16'h1234);
    idle(16'h1234);
    check_eq("err_sticky", {31'h0, addr_error}, 32'h1);
    do_reset();
    step(IPC, 1'b0, DB + 32'h10, 32'h0, 1'b1, 1'b0, 16'h0);
    check_eq("dmem_survives_rst", dReadData, 32'hDEADBEEF);

    // Random phase: fill the words used, then mix traffic across the map
    for (int i = 0; i < 16; i++) step(IPC, 1'b0, DB + 4 * i, $urandom, 1'b0, 1'b1, 16'h0);
    sw = 16'h0;
    for (int blk = 0; blk < 3; blk++) begin
      for (int n = 0; n < 120; n++) begin
        int op = $urandom_range(0, 9);
        if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
        step(rand_pc(), 1'($urandom_range(0, 1)), rand_daddr(), $urandom,
             (op <= 3) || (op == 7), (op >= 4 && op <= 7), sw);
      end
      do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
